// File: rtl/fetch_unit.sv
// Instruction fetch: owns pc, reads one line per cycle into the instruction register (1-cycle load-to-valid).
// Backpressure: while instr_valid && !instr_ready the register, pc and mem_en hold; redirects flush the held instruction.
module fetch_unit #(
    parameter int                    IP_WIDTH   = 8,
    parameter int                    LINE_WIDTH = 32,
    parameter logic [LINE_WIDTH-1:0] END_WORD   = {LINE_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_en,
    output logic [IP_WIDTH-1:0]   mem_ip,
    input  logic [LINE_WIDTH-1:0] mem_line,
    output logic                  instr_valid,
    output logic [LINE_WIDTH-1:0] instr,
    output logic [IP_WIDTH-1:0]   instr_ip,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [IP_WIDTH-1:0]   redirect_ip,
    input  logic                  pipe_empty,
    output logic                  halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IP_WIDTH-1:0]   pc;
    logic [IP_WIDTH-1:0]   pc_nxt;
    logic [LINE_WIDTH-1:0] instr_nxt;
    logic [IP_WIDTH-1:0]   instr_ip_nxt;
    logic                  instr_valid_nxt;
    logic                  halted_nxt;
    logic                  load;
    logic                  is_end;

    assign load   = (state == FETCH) && (!instr_valid || instr_ready) && !redirect;
    assign is_end = (mem_line == END_WORD);
    assign mem_en = load;
    assign mem_ip = pc;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_ip_nxt    = instr_ip;
        instr_valid_nxt = instr_valid;
        halted_nxt      = halted;

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt       = FETCH;
                    pc_nxt          = '0;
                    instr_valid_nxt = 1'b0;
                    halted_nxt      = 1'b0;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_nxt          = redirect_ip;
                    instr_valid_nxt = 1'b0;
                end else if (load) begin
                    if (is_end) begin
                        // End word is swallowed; pc parks on it until a redirect or halt.
                        instr_valid_nxt = instr_valid && !instr_ready;
                        state_nxt       = DRAIN;
                    end else begin
                        instr_nxt       = mem_line;
                        instr_ip_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        pc_nxt          = pc + IP_WIDTH'(1);
                    end
                end else if (instr_valid && instr_ready) begin
                    instr_valid_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_nxt          = redirect_ip;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = FETCH;
                end else begin
                    if (instr_valid && instr_ready) begin
                        instr_valid_nxt = 1'b0;
                    end
                    // A late branch could still pull us back, so wait for the pipe to empty.
                    if (!instr_valid && pipe_empty) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_ip    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_ip    <= instr_ip_nxt;
            instr_valid <= instr_valid_nxt;
            halted      <= halted_nxt;
        end
    end

endmodule
